// File: rtl/fft_bf_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fft_bf_sequencer
// Purpose  : Butterfly address/twiddle sequencer for a 1024-point radix-2 FFT.
//            Optional macro FFT_SEQ_STALL_CNT_EN adds the stall_cnt output.
// Revision : 1.0  initial release
// ============================================================================
module fft_bf_sequencer (
    input  logic        Clk,
    input  logic        reset,
    input  logic        start,
    input  logic        bf_ready,
    input  logic        bf_idle,
    output logic        bf_valid,
    output logic [9:0]  top_idx,
    output logic [9:0]  bot_idx,
    output logic [8:0]  tw_idx,
    output logic [3:0]  stage,
    output logic        bf_last,
    output logic        busy,
    output logic        done
`ifdef FFT_SEQ_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam logic [8:0] K_LAST     = 9'd511;
    localparam logic [3:0] STAGE_LAST = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t     state;
    logic [8:0] k;

    // Packs {top_idx, bot_idx, tw_idx} for butterfly kk of stage st.
    function automatic logic [28:0] bf_index(input logic [8:0] kk, input logic [3:0] st);
        logic [9:0] half;
        logic [9:0] pos;
        logic [9:0] top;
        logic [8:0] tw;
        half = 10'd1 << st;
        pos  = {1'b0, kk} & (half - 10'd1);
        top  = (({1'b0, kk} >> st) << (st + 4'd1)) | pos;
        tw   = pos[8:0] << (4'd9 - st);
        return {top, top + half, tw};
    endfunction

    always_ff @(posedge Clk) begin
        if (reset) begin
            state    <= IDLE;
            k        <= 9'd0;
            stage    <= 4'd0;
            bf_valid <= 1'b0;
            top_idx  <= 10'd0;
            bot_idx  <= 10'd0;
            tw_idx   <= 9'd0;
            bf_last  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state                       <= ISSUE;
                        stage                       <= 4'd0;
                        k                           <= 9'd0;
                        bf_valid                    <= 1'b1;
                        bf_last                     <= 1'b0;
                        busy                        <= 1'b1;
                        {top_idx, bot_idx, tw_idx}  <= bf_index(9'd0, 4'd0);
                    end
                end
                ISSUE: begin
                    // bf_valid is always high here, so bf_ready alone completes the handshake.
                    if (bf_ready) begin
                        if (k == K_LAST) begin
                            state    <= WAIT;
                            bf_valid <= 1'b0;
                            bf_last  <= 1'b0;
                        end else begin
                            k                          <= k + 9'd1;
                            bf_last                    <= (k == K_LAST - 9'd1);
                            {top_idx, bot_idx, tw_idx} <= bf_index(k + 9'd1, stage);
                        end
                    end
                end
                WAIT: begin
                    if (bf_idle) begin
                        if (stage == STAGE_LAST) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state                      <= ISSUE;
                            stage                      <= stage + 4'd1;
                            k                          <= 9'd0;
                            bf_valid                   <= 1'b1;
                            {top_idx, bot_idx, tw_idx} <= bf_index(9'd0, stage + 4'd1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FFT_SEQ_STALL_CNT_EN
    always_ff @(posedge Clk) begin
        if (reset) begin
            stall_cnt <= 16'd0;
        end else if (state == IDLE && start) begin
            stall_cnt <= 16'd0;
        end else if (stall_cnt != 16'hFFFF &&
                     ((state == ISSUE && !bf_ready) || (state == WAIT && !bf_idle))) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire
